// File: rtl/add_sequencer.sv
// add_sequencer: steps the shared ripple adder through a batch of additions.
// Each operation reads X from instruction memory and Y from the register
// file, adds them with the command carry-in and writes the sum back to the
// register file. Source and destination addresses advance by one per
// operation and wrap at the top of their address space.
//
// Optional build macro: SAT_ADD_EN
//   defined   -> a signed overflow writes the saturated value instead of the sum
//   undefined -> the wrapped sum is always written
//
// Handshake: start is a level sampled on the rising edge only while IDLE. busy
// is high from the cycle after that edge until the cycle after done. done is
// a single-cycle pulse. Memory read data is expected one cycle after its
// enable, and a write happens on the edge that ends the cycle with rf_we high.
// The FSM state is held in r_state for observation by checkers.
module add_sequencer #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 5,
    parameter int RF_AW   = 5,
    parameter int LEN_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IMEM_AW-1:0]  cmd_iaddr,
    input  logic [RF_AW-1:0]    cmd_rsrc,
    input  logic [RF_AW-1:0]    cmd_rdst,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_cin,
    output logic                imem_en,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [DATA_W-1:0]   imem_rdata,
    output logic                rf_en,
    output logic [RF_AW-1:0]    rf_raddr,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic                rf_we,
    output logic [RF_AW-1:0]    rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [DATA_W-1:0]   add_x,
    output logic [DATA_W-1:0]   add_y,
    output logic                add_cin,
    input  logic [DATA_W-1:0]   add_sum,
    input  logic                add_cout,
    input  logic                add_ovf,
    output logic                busy,
    output logic                done,
    output logic                cout_any,
    output logic                ovf_any,
    output logic [DATA_W-1:0]   result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ADD   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [IMEM_AW-1:0] IA_ONE  = IMEM_AW'(1);
    localparam logic [RF_AW-1:0]   RA_ONE  = RF_AW'(1);
    localparam logic [LEN_W-1:0]   CNT_ONE = LEN_W'(1);

    state_t               r_state;

    // Command context, advanced after every write-back
    logic [IMEM_AW-1:0]   r_cur_iaddr;
    logic [RF_AW-1:0]     r_cur_rsrc;
    logic [RF_AW-1:0]     r_cur_rdst;
    logic [LEN_W-1:0]     r_cnt;
    logic                 r_cin;
    logic [DATA_W-1:0]    r_sum_q;

    // Registered outputs
    logic                 r_imem_en;
    logic [IMEM_AW-1:0]   r_imem_addr;
    logic                 r_rf_en;
    logic [RF_AW-1:0]     r_rf_raddr;
    logic                 r_rf_we;
    logic [RF_AW-1:0]     r_rf_waddr;
    logic [DATA_W-1:0]    r_rf_wdata;
    logic [DATA_W-1:0]    r_add_x;   // doubles as the captured X operand
    logic [DATA_W-1:0]    r_add_y;   // doubles as the captured Y operand
    logic                 r_add_cin;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cout_any;
    logic                 r_ovf_any;
    logic [DATA_W-1:0]    r_result;

    // Value that will be written back for the addition currently in ADD
    logic [DATA_W-1:0]    w_sum_sel;

`ifdef SAT_ADD_EN
    logic [DATA_W-1:0]    w_sat_val;

    // Clamp toward the sign of X: both operands share that sign on overflow
    assign w_sat_val = r_add_x[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                         : {1'b0, {(DATA_W-1){1'b1}}};
    assign w_sum_sel = add_ovf ? w_sat_val : add_sum;
`else
    assign w_sum_sel = add_sum;
`endif

    // Sequencer FSM; every output is registered and set on entry to its state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur_iaddr <= '0;
            r_cur_rsrc  <= '0;
            r_cur_rdst  <= '0;
            r_cnt       <= '0;
            r_cin       <= 1'b0;
            r_sum_q     <= '0;
            r_imem_en   <= 1'b0;
            r_imem_addr <= '0;
            r_rf_en     <= 1'b0;
            r_rf_raddr  <= '0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_add_x     <= '0;
            r_add_y     <= '0;
            r_add_cin   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cout_any  <= 1'b0;
            r_ovf_any   <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_iaddr <= cmd_iaddr;
                        r_cur_rsrc  <= cmd_rsrc;
                        r_cur_rdst  <= cmd_rdst;
                        r_cnt       <= cmd_len;
                        r_cin       <= cmd_cin;
                        r_cout_any  <= 1'b0;
                        r_ovf_any   <= 1'b0;
                        r_result    <= '0;
                        r_busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_imem_en   <= 1'b1;
                            r_imem_addr <= cmd_iaddr;
                            r_rf_en     <= 1'b1;
                            r_rf_raddr  <= cmd_rsrc;
                            r_state     <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    r_imem_en   <= 1'b0;
                    r_imem_addr <= '0;
                    r_rf_en     <= 1'b0;
                    r_rf_raddr  <= '0;
                    r_state     <= S_WAIT;
                end

                S_WAIT: begin
                    // Read data is valid now; it becomes the adder operands
                    r_add_x   <= imem_rdata;
                    r_add_y   <= rf_rdata;
                    r_add_cin <= r_cin;
                    r_state   <= S_ADD;
                end

                S_ADD: begin
                    r_sum_q    <= w_sum_sel;
                    r_cout_any <= r_cout_any | add_cout;
                    r_ovf_any  <= r_ovf_any | add_ovf;
                    r_add_x    <= '0;
                    r_add_y    <= '0;
                    r_add_cin  <= 1'b0;
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_cur_rdst;
                    r_rf_wdata <= w_sum_sel;
                    r_state    <= S_WB;
                end

                S_WB: begin
                    r_result    <= r_sum_q;
                    r_rf_we     <= 1'b0;
                    r_rf_waddr  <= '0;
                    r_rf_wdata  <= '0;
                    r_cur_iaddr <= r_cur_iaddr + IA_ONE;
                    r_cur_rsrc  <= r_cur_rsrc + RA_ONE;
                    r_cur_rdst  <= r_cur_rdst + RA_ONE;
                    r_cnt       <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // The write lands on this edge, so the next read
                        // already sees it when rsrc and rdst overlap
                        r_imem_en   <= 1'b1;
                        r_imem_addr <= r_cur_iaddr + IA_ONE;
                        r_rf_en     <= 1'b1;
                        r_rf_raddr  <= r_cur_rsrc + RA_ONE;
                        r_state     <= S_FETCH;
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_imem_en <= 1'b0;
                    r_rf_en   <= 1'b0;
                    r_rf_we   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_en   = r_imem_en;
    assign imem_addr = r_imem_addr;
    assign rf_en     = r_rf_en;
    assign rf_raddr  = r_rf_raddr;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign add_x     = r_add_x;
    assign add_y     = r_add_y;
    assign add_cin   = r_add_cin;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cout_any  = r_cout_any;
    assign ovf_any   = r_ovf_any;
    assign result    = r_result;

endmodule

// File: doc/add_sequencer.md
Name: add_sequencer

Overview:
Sequencer that drives the shared 32-bit ripple adder datapath. On a start command it runs LEN additions. Each addition reads operand X from instruction memory and operand Y from the register file, then writes the sum back to the register file. Sits between a host/testbench command interface and the existing instruction memory, register file and adder, replacing hand-driven operand steering.

Parameters:
DATA_W, 32, datapath/adder width
IMEM_AW, 5, instruction memory address width (32 words)
RF_AW, 5, register file address width (32 regs)
LEN_W, 5, width of operation count

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
cmd_iaddr  in  IMEM_AW  first instruction memory address (X source)
cmd_rsrc  in  RF_AW  first register source (Y source)
cmd_rdst  in  RF_AW  first register destination
cmd_len  in  LEN_W  number of additions
cmd_cin  in  1  carry-in applied to every addition
imem_en  out  1  instruction memory read enable
imem_addr  out  IMEM_AW  instruction memory address
imem_rdata  in  DATA_W  read data, valid 1 cycle after imem_en
rf_en  out  1  register file read enable
rf_raddr  out  RF_AW  register read address
rf_rdata  in  DATA_W  read data, valid 1 cycle after rf_en
rf_we  out  1  register write strobe
rf_waddr  out  RF_AW  register write address
rf_wdata  out  DATA_W  register write data
add_x, add_y  out  DATA_W  adder operands
add_cin  out  1  adder carry-in
add_sum  in  DATA_W  adder sum (combinational)
add_cout  in  1  adder carry-out
add_ovf  in  1  adder signed overflow
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse
cout_any  out  1  sticky: any carry-out in this command
ovf_any  out  1  sticky: any overflow in this command
result  out  DATA_W  last written sum

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Internal address and count registers 0. Takes effect mid-operation immediately; rf_we drops with no partial write.
- IDLE: busy=0. When start=1, latch all cmd_* fields and clear cout_any, ovf_any and result.
  - If cmd_len=0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: imem_en=1, imem_addr=cur_iaddr, rf_en=1, rf_raddr=cur_rsrc. Next state WAIT.
- WAIT: capture imem_rdata into x_q and rf_rdata into y_q at the end of the cycle. Next state ADD.
- ADD: add_x=x_q, add_y=y_q, add_cin=cin_q. Register add_sum, add_cout and add_ovf. OR add_cout into cout_any and add_ovf into ovf_any. Next state WB.
- WB: rf_we=1, rf_waddr=cur_rdst, rf_wdata=sum_q; result<=sum_q.
  - Increment cur_iaddr, cur_rsrc and cur_rdst by 1, each wrapping modulo 2^AW.
  - Decrement the remaining count. If it reaches 0, go to DONE; otherwise go to FETCH.
- DONE: done=1 for exactly one cycle. Next state IDLE. A start in this cycle is ignored.
- Latency: start is sampled at edge 0. The first write (rf_we) occurs in cycle 4. done is asserted in cycle 4*LEN+1.
- Address outputs and add_x/add_y are 0 in states that do not use them.
- start while busy is ignored: no latch, no effect on the running command.
- rsrc==rdst is legal: the read in a later op sees the value written in an earlier op, because WB precedes the next FETCH.

Optional Feature:
SAT_ADD_EN
- Defined: in ADD, if add_ovf=1, the sequencer writes the saturated value instead of the raw sum. Saturation is 0x7FFFFFFF when add_x[MSB]=0, else 0x80000000. ovf_any is still set.
- Undefined: the wrapped sum is always written.

Test Plan:
- Basic: imem[0]=0x0F0F0F0E, rf[2]=0x00000005, cmd_iaddr=0, rsrc=2, rdst=3, len=1, cin=0 -> rf[3]=0x0F0F0F13, result matches, cout_any=0, ovf_any=0, rf_we high in cycle 4, done in cycle 5.
- Carry: imem[1]=0xFFFFFFFF, rf[4]=0x00000001 -> written value 0x00000000, cout_any=1, ovf_any=0.
- Overflow: imem[2]=0x7FFFFFFF, rf[5]=0x00000001 -> written value 0x80000000, ovf_any=1. With SAT_ADD_EN the written value is 0x7FFFFFFF.
- Batch and wrap: cmd_iaddr=30, rsrc=31, rdst=10, len=3 -> imem reads at 30, 31, 0; rf reads at 31, 0, 1; writes to 10, 11, 12; done in cycle 13. len=0 -> done in cycle 1 with no writes.
- Busy and reset: start re-pulsed during WAIT with different fields -> ignored, original command completes. rst_n low during ADD -> all outputs 0 immediately, no write, IDLE on release.
